// File: rtl/img_scale_seq_if.sv
// Purpose: bundles the host start/config lines and the ROM/RAM strobes of img_scale_seq.
// Latency: none, wires only; every output on it is driven from a register in img_scale_seq.
// Backpressure: stall (RAM not ready) is the only backpressure and flows from master to slave.
// Ports: master drives start, scale_sel, flip_h, flip_v, stall; slave drives ROM_A, ROM_OE,
//        RAM_A, RAM_WE, RAM_OE, busy, done.
interface img_scale_seq_if;
    logic        start;
    logic        scale_sel;
    logic        flip_h;
    logic        flip_v;
    logic        stall;
    logic [13:0] ROM_A;
    logic        ROM_OE;
    logic [15:0] RAM_A;
    logic        RAM_WE;
    logic        RAM_OE;
    logic        busy;
    logic        done;

    modport master (
        output start, scale_sel, flip_h, flip_v, stall,
        input  ROM_A, ROM_OE, RAM_A, RAM_WE, RAM_OE, busy, done
    );

    modport slave (
        input  start, scale_sel, flip_h, flip_v, stall,
        output ROM_A, ROM_OE, RAM_A, RAM_WE, RAM_OE, busy, done
    );
endinterface

// File: rtl/img_scale_seq.sv
// Purpose: walks a 128x128 ROM image into RAM (stride 256) as a 1x copy or 2x nearest-neighbour upscale, with optional mirroring.
// Latency: pixel issued one edge after it is counted; its RAM write follows ROM_LAT accepted edges later.
// Backpressure: stall=1 freezes counters, write pipeline, state and every output; ignored in IDLE and FIN.
// Ports: clk, rst (async, active high); bus (slave side): start/scale_sel/flip_h/flip_v/stall in,
//        ROM_A/ROM_OE/RAM_A/RAM_WE/RAM_OE/busy/done out, all outputs registered.
module img_scale_seq #(
    parameter int ROM_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    img_scale_seq_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t state, state_nxt;

    logic        cfg_scale, cfg_flip_h, cfg_flip_v;
    logic [7:0]  dx, dy, lim;
    logic        row_end, last_px, advance, issue, pipe_empty;
    logic [6:0]  sx, sy;

    // Destination addresses wait here for the ROM data to come back.
    logic [ROM_LAT-1:0]       pipe_vld;
    logic [ROM_LAT-1:0][15:0] pipe_adr;
    // The pipeline extended by the entry being issued this edge: index 0 is the
    // new entry, index ROM_LAT is the one leaving for the RAM output registers.
    logic [ROM_LAT:0]         ext_vld;
    logic [ROM_LAT:0][15:0]   ext_adr;

    always_comb begin
        lim     = cfg_scale ? 8'd255 : 8'd127;
        row_end = (dx == lim);
        last_px = row_end && (dy == lim);
        // 2x upscale repeats each source pixel twice along both axes.
        sx = cfg_scale ? dx[7:1] : dx[6:0];
        sy = cfg_scale ? dy[7:1] : dy[6:0];
        // 127 - s on a 7-bit value is a bitwise invert.
        if (cfg_flip_h) sx = ~sx;
        if (cfg_flip_v) sy = ~sy;
        advance    = !bus.stall;
        issue      = (state == RUN) && advance;
        ext_vld    = {pipe_vld, issue};
        ext_adr    = {pipe_adr, dy, dx};
        pipe_empty = (pipe_vld == '0);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (issue && last_px) state_nxt = DRAIN;
            // An empty pipeline at an unstalled edge means the last write is
            // being accepted right now, so the job is complete after this edge.
            DRAIN:   if (advance && pipe_empty) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_scale  <= 1'b0;
            cfg_flip_h <= 1'b0;
            cfg_flip_v <= 1'b0;
            dx         <= '0;
            dy         <= '0;
            pipe_vld   <= '0;
            pipe_adr   <= '0;
            bus.ROM_A  <= '0;
            bus.ROM_OE <= 1'b0;
            bus.RAM_A  <= '0;
            bus.RAM_WE <= 1'b0;
            bus.RAM_OE <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
        end else begin
            // Status outputs follow the next state so they are valid from the
            // very edge that accepts the job / enters FIN.
            bus.busy   <= (state_nxt != IDLE);
            bus.RAM_OE <= (state_nxt != IDLE);
            bus.done   <= (state_nxt == FIN);

            if (state == IDLE && bus.start) begin
                cfg_scale  <= bus.scale_sel;
                cfg_flip_h <= bus.flip_h;
                cfg_flip_v <= bus.flip_v;
                dx         <= '0;
                dy         <= '0;
            end

            if (issue) begin
                bus.ROM_A  <= {sy, sx};
                bus.ROM_OE <= 1'b1;
                // Counters park on the final pixel instead of wrapping.
                if (!last_px) begin
                    dx <= row_end ? 8'd0 : dx + 8'd1;
                    if (row_end) dy <= dy + 8'd1;
                end
            end else if (advance) begin
                bus.ROM_OE <= 1'b0;
            end

            if (advance) begin
                pipe_vld   <= ext_vld[ROM_LAT-1:0];
                pipe_adr   <= ext_adr[ROM_LAT-1:0];
                bus.RAM_WE <= ext_vld[ROM_LAT];
                // RAM_A keeps the last written address between strobes.
                if (ext_vld[ROM_LAT]) bus.RAM_A <= ext_adr[ROM_LAT];
            end
        end
    end

endmodule

// File: tb/tb_img_scale_seq.sv
// Purpose: self-checking bench for img_scale_seq, one DUT with ROM_LAT=1 and one with ROM_LAT=3.
// Latency: n/a; a negedge monitor logs accepted ROM reads and RAM writes for the selected DUT.
// Backpressure: stall is driven randomly in one scenario; the reference model is raster arithmetic.
module tb_img_scale_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic start = 1'b0, scale_sel = 1'b0, flip_h = 1'b0, flip_v = 1'b0, stall = 1'b0;
    logic sel = 1'b0;   // 0: ROM_LAT=1 instance, 1: ROM_LAT=3 instance

    img_scale_seq_if bus1 ();
    img_scale_seq_if bus3 ();

    img_scale_seq #(.ROM_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    img_scale_seq #(.ROM_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

    assign bus1.start     = !sel ? start : 1'b0;
    assign bus1.scale_sel = scale_sel;
    assign bus1.flip_h    = flip_h;
    assign bus1.flip_v    = flip_v;
    assign bus1.stall     = !sel ? stall : 1'b0;
    assign bus3.start     = sel ? start : 1'b0;
    assign bus3.scale_sel = scale_sel;
    assign bus3.flip_h    = flip_h;
    assign bus3.flip_v    = flip_v;
    assign bus3.stall     = sel ? stall : 1'b0;

    logic [34:0] o1, o3, m_outs;
    assign o1 = {bus1.ROM_A, bus1.ROM_OE, bus1.RAM_A, bus1.RAM_WE, bus1.RAM_OE, bus1.busy, bus1.done};
    assign o3 = {bus3.ROM_A, bus3.ROM_OE, bus3.RAM_A, bus3.RAM_WE, bus3.RAM_OE, bus3.busy, bus3.done};
    assign m_outs = sel ? o3 : o1;

    logic [13:0] m_rom_a;
    logic [15:0] m_ram_a;
    logic        m_rom_oe, m_ram_we, m_busy, m_done;
    assign m_rom_a  = m_outs[34:21];
    assign m_rom_oe = m_outs[20];
    assign m_ram_a  = m_outs[19:4];
    assign m_ram_we = m_outs[3];
    assign m_busy   = m_outs[1];
    assign m_done   = m_outs[0];

    int checks = 0;
    int errors = 0;

    // ---------------- monitor ----------------
    logic [15:0] wr_ram [65536];
    int          wr_edge[65536];
    logic [13:0] rd_rom [65536];
    int          rd_edge[65536];
    int wr_n = 0, rd_n = 0, edge_n = 0, cyc = 0, start_cyc = 0, done_cyc = 0;
    int done_n = 0, stab_err = 0, stall_n = 0, we_any = 0;
    logic        prev_stall = 1'b0, prev_busy = 1'b0, prev_done = 1'b0;
    logic [34:0] prev_outs = '0;

    always @(negedge clk) begin
        cyc++;
        if (m_busy && !prev_busy) start_cyc = cyc;
        if (m_done) begin
            done_n++;
            done_cyc = cyc;
        end
        if (m_ram_we) we_any++;
        if (prev_stall && prev_busy && !prev_done && m_outs !== prev_outs) stab_err++;
        if (stall && m_busy && !m_done) stall_n++;
        if (!stall && m_busy) begin
            if (m_rom_oe && rd_n < 65536) begin
                rd_rom[rd_n]  = m_rom_a;
                rd_edge[rd_n] = edge_n;
                rd_n++;
            end
            if (m_ram_we && wr_n < 65536) begin
                wr_ram[wr_n]  = m_ram_a;
                wr_edge[wr_n] = edge_n;
                wr_n++;
            end
            edge_n++;
        end
        prev_stall = stall;
        prev_busy  = m_busy;
        prev_done  = m_done;
        prev_outs  = m_outs;
    end

    // ---------------- reference model ----------------
    function automatic logic [15:0] exp_ram(input int k, input bit sc);
        int w;
        w = sc ? 256 : 128;
        return 16'((k / w) * 256 + (k % w));
    endfunction

    function automatic logic [13:0] exp_rom(input int k, input bit sc, input bit fh, input bit fv);
        int w, dx, dy, sx, sy;
        w  = sc ? 256 : 128;
        dx = k % w;
        dy = k / w;
        sx = sc ? dx / 2 : dx;
        sy = sc ? dy / 2 : dy;
        if (fh) sx = 127 - sx;
        if (fv) sy = 127 - sy;
        return 14'(sy * 128 + sx);
    endfunction

    int first_bad = -1;

    // Number of logged writes disagreeing with the model in address, source
    // pixel, or read-to-write distance in accepted edges.
    function automatic int count_bad(input int n, input bit sc, input bit fh, input bit fv, input int lat);
        int bad;
        bad = 0;
        first_bad = -1;
        for (int k = 0; k < n; k++) begin
            if (wr_ram[k] !== exp_ram(k, sc) || rd_rom[k] !== exp_rom(k, sc, fh, fv) ||
                (wr_edge[k] - rd_edge[k]) != lat) begin
                if (bad == 0) first_bad = k;
                bad++;
            end
        end
        return bad;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        wr_n = 0; rd_n = 0; edge_n = 0; done_n = 0; stab_err = 0; stall_n = 0;
        start_cyc = 0; done_cyc = 0;
    endtask

    task automatic start_job(input bit sc, input bit fh, input bit fv);
        clear_mon();
        scale_sel = sc; flip_h = fh; flip_v = fv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Config lines wander after acceptance; the job must keep its latched values.
        scale_sel = 1'($urandom); flip_h = 1'($urandom); flip_v = 1'($urandom);
    endtask

    task automatic wait_done(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (done_n > 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        cycles(3);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        sel = 1'b0; start = 1'b0; stall = 1'b0;
        #2 rst = 1'b1;
        cycles(2);
        checks++;
        if (o1 !== '0) begin errors++; $display("FAIL reset_outs_lat1: got %h expected 0", o1); end
        checks++;
        if (o3 !== '0) begin errors++; $display("FAIL reset_outs_lat3: got %h expected 0", o3); end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            stall = 1'($urandom);
            cycles(1);
        end
        stall = 1'b0;
        checks++;
        if (o1 !== '0) begin errors++; $display("FAIL idle_stall_outs: got %h expected 0", o1); end
    endtask

    task automatic test_2x_start_busy();
        int          idx[5] = '{0, 1, 2, 256, 512};
        logic [15:0] er [5] = '{16'h0000, 16'h0001, 16'h0002, 16'h0100, 16'h0200};
        logic [13:0] eo [5] = '{14'h0000, 14'h0000, 14'h0001, 14'h0000, 14'h0080};
        int bad;
        sel = 1'b0;
        start_job(1'b1, 1'b0, 1'b0);
        cycles(300);
        start = 1'b1; scale_sel = 1'b0; flip_h = 1'b1; flip_v = 1'b1;
        cycles(1);
        start = 1'b0;
        checks++;
        if (m_busy !== 1'b1) begin errors++; $display("FAIL start_while_busy_busy: got %b expected 1", m_busy); end
        cycles(900);
        checks++;
        if (wr_n <= 600) begin errors++; $display("FAIL partial_write_count: got %0d expected >600", wr_n); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({wr_ram[idx[i]], rd_rom[idx[i]]} !== {er[i], eo[i]}) begin
                errors++;
                $display("FAIL 2x_pair_%0d: got ram %h rom %h expected ram %h rom %h",
                         idx[i], wr_ram[idx[i]], rd_rom[idx[i]], er[i], eo[i]);
            end
        end
        bad = count_bad(wr_n, 1'b1, 1'b0, 1'b0, 1);
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL 2x_partial_seq: got %0d bad writes (first %0d) expected 0", bad, first_bad); end
        checks++;
        if (done_n !== 0) begin errors++; $display("FAIL 2x_partial_no_done: got %0d expected 0", done_n); end
    endtask

    task automatic test_reset_mid_run();
        int nwe;
        nwe = we_any;
        rst = 1'b1;
        #1;
        checks++;
        if (o1 !== '0) begin errors++; $display("FAIL mid_run_reset_outs: got %h expected 0", o1); end
        cycles(3);
        rst = 1'b0;
        cycles(20);
        checks++;
        if (we_any !== nwe) begin errors++; $display("FAIL mid_run_reset_writes: got %0d expected %0d", we_any, nwe); end
        checks++;
        if (done_n !== 0 || m_busy !== 1'b0) begin
            errors++; $display("FAIL mid_run_reset_done: got done_n %0d busy %b expected 0 0", done_n, m_busy);
        end
    endtask

    task automatic test_stall();
        int bad;
        sel = 1'b0;
        start_job(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            stall = ($urandom_range(0, 99) < 30);
        end
        stall = 1'b0;
        cycles(2);
        checks++;
        if (wr_n <= 1000) begin errors++; $display("FAIL stall_write_count: got %0d expected >1000", wr_n); end
        bad = count_bad(wr_n, 1'b0, 1'b0, 1'b1, 1);
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL stall_seq: got %0d bad writes (first %0d) expected 0", bad, first_bad); end
        checks++;
        if (stab_err !== 0) begin errors++; $display("FAIL stall_stable: got %0d changed edges expected 0", stab_err); end
        checks++;
        if (stall_n == 0) begin errors++; $display("FAIL stall_applied: got %0d stalled edges expected >0", stall_n); end
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(2);
    endtask

    task automatic test_2x_flipv();
        bit to;
        int bad;
        sel = 1'b0;
        start_job(1'b1, 1'b0, 1'b1);
        wait_done(70000, to);
        checks++;
        if (to) begin errors++; $display("FAIL 2x_done_timeout: got timeout expected done"); end
        checks++;
        if (wr_n !== 65536 || rd_n !== 65536) begin
            errors++; $display("FAIL 2x_counts: got wr %0d rd %0d expected 65536 65536", wr_n, rd_n);
        end
        bad = count_bad(65536, 1'b1, 1'b0, 1'b1, 1);
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL 2x_flipv_seq: got %0d bad writes (first %0d) expected 0", bad, first_bad); end
        checks++;
        if ({wr_ram[0], rd_rom[0], wr_ram[256], rd_rom[256]} !== {16'h0000, 14'h3F80, 16'h0100, 14'h3F80}) begin
            errors++; $display("FAIL 2x_flipv_first: got %h/%h %h/%h expected 0000/3f80 0100/3f80",
                               wr_ram[0], rd_rom[0], wr_ram[256], rd_rom[256]);
        end
        checks++;
        if ({wr_ram[65535], rd_rom[65535]} !== {16'hFFFF, 14'h007F}) begin
            errors++; $display("FAIL 2x_flipv_last: got %h/%h expected ffff/007f", wr_ram[65535], rd_rom[65535]);
        end
        checks++;
        if (done_cyc - start_cyc !== 65538) begin
            errors++; $display("FAIL 2x_done_latency: got %0d expected 65538", done_cyc - start_cyc);
        end
        checks++;
        if (done_n !== 1 || m_busy !== 1'b0) begin
            errors++; $display("FAIL 2x_done_pulse: got done_n %0d busy %b expected 1 0", done_n, m_busy);
        end
    endtask

    task automatic test_1x_fliph_lat3();
        bit to;
        int bad, hi;
        sel = 1'b1;
        start_job(1'b0, 1'b1, 1'b0);
        wait_done(20000, to);
        checks++;
        if (to) begin errors++; $display("FAIL lat3_done_timeout: got timeout expected done"); end
        checks++;
        if (wr_n !== 16384) begin errors++; $display("FAIL lat3_write_count: got %0d expected 16384", wr_n); end
        bad = count_bad(16384, 1'b0, 1'b1, 1'b0, 3);
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL lat3_seq: got %0d bad writes (first %0d) expected 0", bad, first_bad); end
        checks++;
        if ({wr_ram[0], rd_rom[0], wr_ram[127], rd_rom[127], wr_ram[128], rd_rom[128]} !==
            {16'h0000, 14'h007F, 16'h007F, 14'h0000, 16'h0100, 14'h00FF}) begin
            errors++; $display("FAIL fliph_pairs: got %h/%h %h/%h %h/%h expected 0000/007f 007f/0000 0100/00ff",
                               wr_ram[0], rd_rom[0], wr_ram[127], rd_rom[127], wr_ram[128], rd_rom[128]);
        end
        hi = 0;
        for (int k = 0; k < wr_n; k++) if (wr_ram[k][15] || wr_ram[k][7]) hi++;
        checks++;
        if (hi !== 0) begin errors++; $display("FAIL 1x_range: got %0d out-of-range writes expected 0", hi); end
        checks++;
        if (done_cyc - start_cyc !== 16388) begin
            errors++; $display("FAIL lat3_done_latency: got %0d expected 16388", done_cyc - start_cyc);
        end
        checks++;
        if (done_n !== 1 || m_busy !== 1'b0) begin
            errors++; $display("FAIL lat3_done_pulse: got done_n %0d busy %b expected 1 0", done_n, m_busy);
        end
    endtask

    initial begin
        test_reset();
        test_2x_start_busy();
        test_reset_mid_run();
        test_stall();
        test_2x_flipv();
        test_1x_fliph_lat3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/img_scale_seq.md
Name: img_scale_seq

Overview:
- Sequences the ROM→RAM image transfer path: reads a 128x128 source image from ROM and writes a 1x copy or a 2x nearest-neighbour upscale into RAM.
- RAM row stride is fixed at 256 words.
- Adds to the basic copy: a start/busy/done handshake, per-job configuration (scale, horizontal/vertical flip), a ROM read-latency pipeline and a RAM stall input.
- Sits between the system host (start/config) and the ROM/RAM macros.

Parameters:
- ROM_LAT, 1, ROM read latency in cycles, legal 1..4; RAM write of a pixel lags its ROM read by exactly ROM_LAT accepted cycles.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  job request; sampled only in IDLE
- scale_sel  input  1  0 = 1x copy (128x128 dest), 1 = 2x upscale (256x256 dest); latched at start
- flip_h  input  1  mirror horizontally; latched at start
- flip_v  input  1  mirror vertically; latched at start
- stall  input  1  RAM not ready; freezes the whole pipeline
- ROM_A  output  14  source address {sy[6:0], sx[6:0]}
- ROM_OE  output  1  ROM read enable
- RAM_A  output  16  destination address {dy[7:0], dx[7:0]}
- RAM_WE  output  1  RAM write strobe
- RAM_OE  output  1  RAM enable, high while busy
- busy  output  1  job in progress
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async): state = IDLE. ROM_A=0, ROM_OE=0, RAM_A=0, RAM_WE=0, RAM_OE=0, busy=0, done=0. Pipeline valid bits and counters are cleared.
- Reset mid-job aborts the job with no done pulse and no further writes.
- All outputs are registered.
- States: IDLE, RUN, DRAIN, FIN.
  - IDLE: start=1 at an edge latches scale_sel/flip_h/flip_v, clears dx/dy, and goes to RUN. busy=1 and RAM_OE=1 from that edge.
  - RUN: one pixel is issued per edge with stall=0. Raster order, dx fastest.
    - Limits: dx,dy run 0..127 at 1x and 0..255 at 2x.
    - After the last pixel (dx=dy=max) is issued, go to DRAIN.
  - DRAIN: no new issues (ROM_OE=0). Wait until the pipeline holds no valid write, then go to FIN.
  - FIN: lasts one cycle with done=1. Next edge returns to IDLE; busy, RAM_OE and done go low.
- Source address mapping:
  - sx = scale ? dx>>1 : dx; sy likewise from dy.
  - flip_h: sx = 127 - sx. flip_v: sy = 127 - sy.
  - ROM_A = {sy[6:0], sx[6:0]}.
- Issue: ROM_A and ROM_OE=1 are registered at the issue edge.
- Write pipeline: an ROM_LAT-deep shift register of {valid, RAM_A}. RAM_WE=valid at the output stage; RAM_A is held from that stage.
- Timing with no stall, start accepted at edge E0:
  - pixel k is issued at E(k+1);
  - its RAM_WE is high after E(k+1+ROM_LAT);
  - done is high during the cycle after E(N+ROM_LAT+1), with N = 16384 (1x) or 65536 (2x).
- Stall:
  - When stall=1 at an edge, counters, pipeline, state and all outputs hold their values; RAM_WE may stay high.
  - A write is accepted only at an edge with RAM_WE=1 and stall=0.
  - Stall in IDLE/FIN has no effect.
- Boundaries:
  - start while busy is ignored; config inputs are ignored except at acceptance.
  - start high in the FIN cycle is ignored. A new job is accepted no earlier than the edge after returning to IDLE.
  - Counters wrap dx→0 with dy+1 at the row end. The final pixel does not wrap into a second pass.
  - ROM_A and RAM_A hold their last values when not strobed.

Test Plan:
- 2x, no flip, ROM_LAT=1, no stall:
  - first writes (RAM_A/ROM_A) are 0x0000/0x0000, 0x0001/0x0000, 0x0002/0x0001;
  - RAM_A=0x0100 pairs with ROM_A 0x0000, and 0x0200 with 0x0080;
  - last write is 0xFFFF/0x3FFF; 65536 writes total; done is 1 cycle, 65538 cycles after start acceptance.
- 1x, flip_h=1, flip_v=0:
  - RAM_A 0x0000 → ROM_A 0x007F, 0x007F → 0x0000, 0x0100 → 0x00FF;
  - 16384 writes; no RAM_A with dx or dy ≥ 128.
- 2x, flip_v=1: RAM_A 0x0000 and 0x0100 → ROM_A 0x3F80; final 0xFFFF → 0x007F.
- Random stall pulses (30%) during a 1x job:
  - accepted-write sequence is identical to the no-stall run;
  - no write is lost or duplicated;
  - outputs are stable across stalled edges.
- ROM_LAT=3:
  - each RAM_WE occurs exactly 3 accepted edges after its ROM_OE;
  - done comes 16388 cycles after start at 1x.
- Control edge cases:
  - start pulsed while busy → no restart and counters undisturbed;
  - rst asserted mid-RUN → all outputs 0 immediately, no done;
  - a new start afterwards runs a full clean job.
